// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared types for the load/store path.
//   mem_size_e  : access size presented by the decoder (byte / half / word)
//   lsu_state_e : load_store_unit sequencing states
//   BE_*        : byte-enable patterns before shifting into their lane
//   is_misaligned() : half at odd address, or word not on a 4-byte boundary
//   lane_offset()   : byte lane an access lands on, with the low address
//                     bits that the size cannot use forced to zero
// -----------------------------------------------------------------------------
package riscv_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE  = 2'b00,
        MEM_HALFW = 2'b01,
        MEM_WORD  = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } lsu_state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] lo);
        case (size)
            MEM_BYTE:  return 1'b0;
            MEM_HALFW: return lo[0];
            default:   return lo != 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] lane_offset(input mem_size_e size, input logic [1:0] lo);
        case (size)
            MEM_BYTE:  return lo;
            MEM_HALFW: return {lo[1], 1'b0};
            default:   return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// -----------------------------------------------------------------------------
// lsu_data_align
// Purely combinational lane logic for the load/store unit.
// Store side:
//   st_size, st_off, store_data -> be (byte enables), wdata (lane-replicated)
// Load side:
//   ld_size, ld_off, ld_usign, rdata -> ldata (shifted down, sign/zero extended)
// Offsets are expected to be already aligned to the access size.
// -----------------------------------------------------------------------------
module lsu_data_align
    import riscv_pkg::*;
(
    input  mem_size_e   st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] store_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,

    input  mem_size_e   ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_usign,
    input  logic [31:0] rdata,
    output logic [31:0] ldata
);

    logic [31:0] shifted;

    always_comb begin
        be    = BE_WORD;
        wdata = store_data;
        case (st_size)
            MEM_BYTE: begin
                be    = BE_BYTE << st_off;
                wdata = {4{store_data[7:0]}};
            end
            MEM_HALFW: begin
                be    = BE_HALF << {st_off[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = BE_WORD;
                wdata = store_data;
            end
        endcase
    end

    always_comb begin
        shifted = rdata >> {ld_off, 3'b000};
        ldata   = shifted;
        case (ld_size)
            MEM_BYTE:  ldata = {{24{~ld_usign & shifted[7]}},  shifted[7:0]};
            MEM_HALFW: ldata = {{16{~ld_usign & shifted[15]}}, shifted[15:0]};
            default:   ldata = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Sequences one load or store per instruction onto a simple req/gnt/rvalid bus,
// stalling the pipeline until the access finishes, times out, or traps.
//
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (no bus cycle, misaligned pulse). Without it misaligned is tied to 0
// and the unusable low address bits are ignored.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   mem_read, mem_write   access request from the current instruction
//   mem_size              byte / half / word
//   mem_usign_load        1 = zero-extend load, 0 = sign-extend
//   addr, store_data      ALU byte address, rs2 value
//   load_data             extended load result (valid in DONE)
//   stall                 high while the access is in progress
//   bus_err               one-cycle pulse in DONE after a timeout
//   misaligned            one-cycle pulse in DONE after a trapped access
//   bus_*                 word-aligned memory bus
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for mem_read/mem_write; captures the access when seen
// REQ   | bus_req high, holding address/enables/data until bus_gnt
// WAIT  | load granted, waiting for bus_rvalid
// DONE  | one cycle with stall low; result/error pulses visible
// -----------------------------------------------------------------------------
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  mem_size_e   mem_size,
    input  logic        mem_usign_load,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        bus_err,
    output logic        misaligned,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q;

    logic        we_q;
    logic        usign_q;
    mem_size_e   size_q;
    logic [1:0]  off_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] ld_q;
    logic        err_q;

    logic        access;
    logic        timeout;
    logic        capture;
    logic        tout_hit;
    logic [1:0]  off_now;
    logic [3:0]  be_w;
    logic [31:0] wdata_w;
    logic [31:0] ldata_w;

`ifdef LSU_MISALIGN_TRAP_EN
    logic        mis_now;
    logic        mis_q;
    assign mis_now = is_misaligned(mem_size, addr[1:0]);
`endif

    assign access  = mem_read | mem_write;
    assign off_now = lane_offset(mem_size, addr[1:0]);
    assign timeout = (cnt_q == CNT_LAST);

    lsu_data_align u_align (
        .st_size    (mem_size),
        .st_off     (off_now),
        .store_data (store_data),
        .be         (be_w),
        .wdata      (wdata_w),
        .ld_size    (size_q),
        .ld_off     (off_q),
        .ld_usign   (usign_q),
        .rdata      (bus_rdata),
        .ldata      (ldata_w)
    );

    // A normal completion in the last allowed cycle wins over the timeout.
    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        capture  = 1'b0;
        tout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    stall = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                    state_d = mis_now ? DONE : REQ;
`else
                    state_d = REQ;
`endif
                end
            end
            REQ: begin
                stall = 1'b1;
                if (bus_gnt) begin
                    if (we_q) begin
                        state_d = DONE;
                    end else if (bus_rvalid) begin
                        capture = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (timeout) begin
                    tout_hit = 1'b1;
                    state_d  = DONE;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (bus_rvalid) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else if (timeout) begin
                    tout_hit = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
        end else if (state_q == REQ || state_q == WAIT) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            usign_q <= 1'b0;
            size_q  <= MEM_BYTE;
            off_q   <= 2'b00;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            ld_q    <= '0;
            err_q   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            if (state_q == IDLE && access) begin
                // mem_write wins when both are set: the access is a store.
                we_q    <= mem_write;
                usign_q <= mem_usign_load;
                size_q  <= mem_size;
                off_q   <= off_now;
                addr_q  <= {addr[31:2], 2'b00};
                be_q    <= be_w;
                wdata_q <= wdata_w;
                err_q   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                mis_q   <= mis_now;
                if (mis_now) begin
                    ld_q <= '0;
                end
`endif
            end
            if (capture) begin
                ld_q <= ldata_w;
            end
            if (tout_hit) begin
                ld_q  <= '0;
                err_q <= 1'b1;
            end
        end
    end

    assign bus_req   = (state_q == REQ);
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
    assign load_data = ld_q;
    assign bus_err   = (state_q == DONE) & err_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = (state_q == DONE) & mis_q;
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Table of directed accesses plus randomized accesses against a reference
// model, and hand sequences for pulse width and reset during WAIT.
// Honours LSU_MISALIGN_TRAP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_load_store_unit;
    import riscv_pkg::*;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    mem_size_e   mem_size;
    logic        mem_usign_load;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        stall;
    logic        bus_err;
    logic        misaligned;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int checks   = 0;
    int failures = 0;

    load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_size       (mem_size),
        .mem_usign_load (mem_usign_load),
        .addr           (addr),
        .store_data     (store_data),
        .load_data      (load_data),
        .stall          (stall),
        .bus_err        (bus_err),
        .misaligned     (misaligned),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_be         (bus_be),
        .bus_wdata      (bus_wdata),
        .bus_gnt        (bus_gnt),
        .bus_rvalid     (bus_rvalid),
        .bus_rdata      (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_store;
        bit          both;
        bit          usign;
        mem_size_e   size;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          gd;     // REQ cycles before gnt
        int          rd;     // WAIT cycles before rvalid (0 = with gnt)
    } op_t;

    typedef struct {
        int          lat;
        bit          nobus;
        logic [31:0] addr;
        logic [3:0]  be;
        bit          we;
        logic [31:0] wdata;
        bit          chk_wdata;
        logic [31:0] ld;
        bit          chk_ld;
        bit          err;
        bit          mis;
    } exp_t;

    typedef struct {
        int          lat;
        int          stall_cycles;
        bit          saw_req;
        bit          stable;
        logic [31:0] addr;
        logic [3:0]  be;
        bit          we;
        logic [31:0] wdata;
        logic [31:0] ld;
        bit          err;
        bit          mis;
        bit          req_in_done;
    } obs_t;

    typedef struct {
        op_t  op;
        exp_t ex;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic op_t mk_op(input bit st, input bit both, input mem_size_e sz,
                                  input bit us, input logic [31:0] a, input logic [31:0] sd,
                                  input logic [31:0] rdv, input int gd, input int rd);
        op_t o;
        o.is_store = st; o.both = both; o.size = sz; o.usign = us;
        o.addr = a; o.sdata = sd; o.rdata = rdv; o.gd = gd; o.rd = rd;
        return o;
    endfunction

    function automatic exp_t mk_exp(input int lat, input bit nobus, input logic [31:0] a,
                                    input logic [3:0] be, input bit we, input logic [31:0] wd,
                                    input bit cw, input logic [31:0] ld, input bit cl,
                                    input bit err, input bit mis);
        exp_t e;
        e.lat = lat; e.nobus = nobus; e.addr = a; e.be = be; e.we = we; e.wdata = wd;
        e.chk_wdata = cw; e.ld = ld; e.chk_ld = cl; e.err = err; e.mis = mis;
        return e;
    endfunction

    task automatic add(input op_t o, input exp_t e);
        vec_t v;
        v.op = o;
        v.ex = e;
        tbl.push_back(v);
    endtask

    // Reference model: derives results straight from the access rules.
    function automatic exp_t model(input op_t op);
        exp_t        e;
        int          off;
        int          v;
        logic [31:0] sh;
        e = mk_exp(0, 0, 0, 0, op.is_store, 0, op.is_store, 0, !op.is_store, 0, 0);
        if (TRAP && ((op.size == MEM_HALFW && op.addr[0]) ||
                     (op.size == MEM_WORD && op.addr[1:0] != 2'b00))) begin
            e.lat = 2; e.nobus = 1; e.mis = 1; e.ld = 0; e.chk_ld = 1; e.chk_wdata = 0;
            return e;
        end
        off = int'(op.addr % 4);
        if (op.size == MEM_HALFW) off = (off / 2) * 2;
        if (op.size == MEM_WORD)  off = 0;
        e.addr = op.addr - (op.addr % 4);
        case (op.size)
            MEM_BYTE: begin
                e.be    = 4'(1 << off);
                e.wdata = op.sdata[7:0] * 32'h0101_0101;
            end
            MEM_HALFW: begin
                e.be    = 4'(3 << off);
                e.wdata = op.sdata[15:0] * 32'h0001_0001;
            end
            default: begin
                e.be    = 4'd15;
                e.wdata = op.sdata;
            end
        endcase
        sh = op.rdata >> (8 * off);
        case (op.size)
            MEM_BYTE: begin
                v = int'(sh & 32'hFF);
                if (!op.usign && v > 127) v -= 256;
                e.ld = 32'(v);
            end
            MEM_HALFW: begin
                v = int'(sh & 32'hFFFF);
                if (!op.usign && v > 32767) v -= 65536;
                e.ld = 32'(v);
            end
            default: e.ld = sh;
        endcase
        e.lat = op.is_store ? (1 + op.gd + 1 + 1) : (1 + op.gd + 1 + op.rd + 1);
        return e;
    endfunction

    // Presents one instruction and plays the bus side until stall drops.
    task automatic run_op(input op_t op, output obs_t ob);
        int gcnt;
        int wcnt;
        bit done;
        ob = '{default: 0};
        @(negedge clk);
        mem_read       = !op.is_store || op.both;
        mem_write      = op.is_store;
        mem_size       = op.size;
        mem_usign_load = op.usign;
        addr           = op.addr;
        store_data     = op.sdata;
        bus_gnt        = 1'b0;
        bus_rvalid     = 1'b0;
        bus_rdata      = $urandom;
        #1;
        ob.lat = 1;
        if (stall) ob.stall_cycles++;
        gcnt = 0;
        wcnt = 0;
        done = 0;
        while (!done && ob.lat < 40) begin
            @(negedge clk);
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b0;
            bus_rdata  = $urandom;
            #1;
            ob.lat++;
            if (!stall) begin
                done           = 1;
                ob.err         = bus_err;
                ob.mis         = misaligned;
                ob.ld          = load_data;
                ob.req_in_done = bus_req;
                mem_read       = 1'b0;
                mem_write      = 1'b0;
            end else begin
                ob.stall_cycles++;
                if (bus_req) begin
                    if (!ob.saw_req) begin
                        ob.saw_req = 1; ob.stable = 1;
                        ob.addr = bus_addr; ob.be = bus_be; ob.we = bus_we; ob.wdata = bus_wdata;
                    end else if (bus_addr !== ob.addr || bus_be !== ob.be ||
                                 bus_we !== ob.we || bus_wdata !== ob.wdata) begin
                        ob.stable = 0;
                    end
                    if (gcnt == op.gd) begin
                        bus_gnt = 1'b1;
                        if (!op.is_store && op.rd == 0) begin
                            bus_rvalid = 1'b1;
                            bus_rdata  = op.rdata;
                        end
                    end
                    gcnt++;
                end else begin
                    wcnt++;
                    if (wcnt == op.rd) begin
                        bus_rvalid = 1'b1;
                        bus_rdata  = op.rdata;
                    end
                end
            end
        end
        if (!done) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    endtask

    task automatic check_op(input string tag, input obs_t ob, input exp_t ex);
        chk({tag, "_latency"}, ob.lat, ex.lat);
        chk({tag, "_stall_cycles"}, ob.stall_cycles, ex.lat - 1);
        chk({tag, "_bus_req_seen"}, 32'(ob.saw_req), 32'(!ex.nobus));
        if (!ex.nobus) begin
            chk({tag, "_bus_addr"}, ob.addr, ex.addr);
            chk({tag, "_bus_be"}, 32'(ob.be), 32'(ex.be));
            chk({tag, "_bus_we"}, 32'(ob.we), 32'(ex.we));
            chk({tag, "_bus_stable"}, 32'(ob.stable), 32'd1);
            if (ex.chk_wdata) chk({tag, "_bus_wdata"}, ob.wdata, ex.wdata);
        end
        chk({tag, "_req_in_done"}, 32'(ob.req_in_done), 32'd0);
        if (ex.chk_ld) chk({tag, "_load_data"}, ob.ld, ex.ld);
        chk({tag, "_bus_err"}, 32'(ob.err), 32'(ex.err));
        chk({tag, "_misaligned"}, 32'(ob.mis), 32'(ex.mis));
    endtask

    initial begin
        obs_t ob;
        op_t  op;
        exp_t ex;

        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_size = MEM_BYTE;
        mem_usign_load = 1'b0; addr = '0; store_data = '0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;

        // Directed vectors
        add(mk_op(1, 0, MEM_BYTE,  0, 32'h1003, 32'h0000_00AB, 0, 0, 0),
            mk_exp(3, 0, 32'h1000, 4'b1000, 1, 32'hABAB_ABAB, 1, 0, 0, 0, 0));
        add(mk_op(0, 0, MEM_BYTE,  0, 32'h2001, 0, 32'h0000_8000, 0, 1),
            mk_exp(4, 0, 32'h2000, 4'b0010, 0, 0, 0, 32'hFFFF_FF80, 1, 0, 0));
        add(mk_op(0, 0, MEM_BYTE,  1, 32'h2001, 0, 32'h0000_8000, 0, 1),
            mk_exp(4, 0, 32'h2000, 4'b0010, 0, 0, 0, 32'h0000_0080, 1, 0, 0));
        add(mk_op(0, 0, MEM_HALFW, 0, 32'h2002, 0, 32'h8001_0000, 0, 0),
            mk_exp(3, 0, 32'h2000, 4'b1100, 0, 0, 0, 32'hFFFF_8001, 1, 0, 0));
        if (TRAP)
            add(mk_op(0, 0, MEM_WORD, 0, 32'h3002, 0, 32'h1234_5678, 0, 1),
                mk_exp(2, 1, 0, 0, 0, 0, 0, 32'h0, 1, 0, 1));
        else
            add(mk_op(0, 0, MEM_WORD, 0, 32'h3002, 0, 32'h1234_5678, 0, 1),
                mk_exp(4, 0, 32'h3000, 4'b1111, 0, 0, 0, 32'h1234_5678, 1, 0, 0));
        add(mk_op(1, 0, MEM_HALFW, 0, 32'h4006, 32'h1234_CDEF, 0, 2, 0),
            mk_exp(5, 0, 32'h4004, 4'b1100, 1, 32'hCDEF_CDEF, 1, 0, 0, 0, 0));
        add(mk_op(1, 1, MEM_WORD,  0, 32'h5000, 32'hDEAD_BEEF, 0, 1, 0),
            mk_exp(4, 0, 32'h5000, 4'b1111, 1, 32'hDEAD_BEEF, 1, 0, 0, 0, 0));
        add(mk_op(0, 0, MEM_HALFW, 1, 32'h6000, 0, 32'h0000_F00D, 0, 2),
            mk_exp(5, 0, 32'h6000, 4'b0011, 0, 0, 0, 32'h0000_F00D, 1, 0, 0));
        add(mk_op(0, 0, MEM_WORD,  0, 32'h7000, 0, 32'h1111_1111, 99, 0),
            mk_exp(10, 0, 32'h7000, 4'b1111, 0, 0, 0, 32'h0, 1, 1, 0));
        add(mk_op(0, 0, MEM_WORD,  0, 32'h7004, 0, 32'h2222_2222, 0, 99),
            mk_exp(10, 0, 32'h7004, 4'b1111, 0, 0, 0, 32'h0, 1, 1, 0));
        add(mk_op(1, 0, MEM_BYTE,  0, 32'h8000, 32'h0000_005A, 0, 99, 0),
            mk_exp(10, 0, 32'h8000, 4'b0001, 1, 32'h5A5A_5A5A, 1, 32'h0, 1, 1, 0));
        if (TRAP)
            add(mk_op(0, 0, MEM_HALFW, 0, 32'h2003, 0, 32'hBEEF_1234, 0, 1),
                mk_exp(2, 1, 0, 0, 0, 0, 0, 32'h0, 1, 0, 1));
        else
            add(mk_op(0, 0, MEM_HALFW, 0, 32'h2003, 0, 32'hBEEF_1234, 0, 1),
                mk_exp(4, 0, 32'h2000, 4'b1100, 0, 0, 0, 32'hFFFF_BEEF, 1, 0, 0));

        // Reset state
        #1;
        chk("reset_stall",      32'(stall),      0);
        chk("reset_bus_req",    32'(bus_req),    0);
        chk("reset_bus_we",     32'(bus_we),     0);
        chk("reset_bus_addr",   bus_addr,        0);
        chk("reset_bus_be",     32'(bus_be),     0);
        chk("reset_bus_wdata",  bus_wdata,       0);
        chk("reset_load_data",  load_data,       0);
        chk("reset_bus_err",    32'(bus_err),    0);
        chk("reset_misaligned", 32'(misaligned), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_op(tbl[i].op, ob);
            check_op($sformatf("vec%0d", i), ob, tbl[i].ex);
            if (tbl[i].ex.err || tbl[i].ex.mis) begin
                @(negedge clk);
                #1;
                chk($sformatf("vec%0d_pulse_end", i), {30'd0, bus_err, misaligned}, 0);
            end
        end

        // Randomized accesses against the model
        for (int i = 0; i < 40; i++) begin
            op.is_store = 1'($urandom_range(0, 1));
            op.both     = op.is_store & 1'($urandom_range(0, 1));
            op.usign    = 1'($urandom_range(0, 1));
            op.size     = mem_size_e'($urandom_range(0, 2));
            op.addr     = $urandom;
            op.sdata    = $urandom;
            op.rdata    = $urandom;
            op.gd       = int'($urandom_range(0, 3));
            op.rd       = int'($urandom_range(0, 3));
            ex = model(op);
            run_op(op, ob);
            check_op($sformatf("rnd%0d", i), ob, ex);
        end

        // Reset while in WAIT, then a late rvalid
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; mem_size = MEM_WORD; addr = 32'h9000;
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        @(negedge clk);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        #1;
        chk("rst_wait_entered", {30'd0, stall, bus_req}, 32'b10);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        mem_read = 1'b0;
        #1;
        chk("rst_wait_bus_req",   32'(bus_req),   0);
        chk("rst_wait_stall",     32'(stall),     0);
        chk("rst_wait_bus_addr",  bus_addr,       0);
        chk("rst_wait_bus_be",    32'(bus_be),    0);
        chk("rst_wait_load_data", load_data,      0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        bus_rvalid = 1'b0;
        #1;
        chk("late_rvalid_stall",     32'(stall),   0);
        chk("late_rvalid_bus_req",   32'(bus_req), 0);
        chk("late_rvalid_load_data", load_data,    0);
        chk("late_rvalid_bus_err",   32'(bus_err), 0);

        // Recovery after reset
        op = mk_op(0, 0, MEM_BYTE, 0, 32'hA003, 0, 32'h7F00_0000, 1, 1);
        ex = model(op);
        run_op(op, ob);
        check_op("post_reset", ob, ex);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
